// File: rtl/lcd_text_arbiter_if.sv
// Bundle of every signal around the text-VRAM arbiter: LCD fetch port, CPU port,
// clear command and the VRAM primitive. The slave modport is the arbiter; master is its surroundings.
interface lcd_text_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              lcd_req;
    logic [ADDR_W-1:0] lcd_addr;
    logic [DATA_W-1:0] lcd_data;
    logic              lcd_valid;

    // CPU port handshake: a request transfers in any cycle where cpu_valid and
    // cpu_ready are both 1; the requester holds cpu_valid and its payload until then.
    // Reads answer with a one-cycle cpu_rvalid pulse three cycles after acceptance.
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              clr_start;
    logic [DATA_W-1:0] clr_char;
    logic              clr_busy;
    logic              clr_done;
    logic              clr_state;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  lcd_req, lcd_addr,
        output lcd_data, lcd_valid,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        input  clr_start, clr_char,
        output clr_busy, clr_done, clr_state,
        output ram_ce, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output lcd_req, lcd_addr,
        input  lcd_data, lcd_valid,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        output clr_start, clr_char,
        input  clr_busy, clr_done, clr_state,
        input  ram_ce, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/lcd_text_arbiter.sv
// Single-port text VRAM arbiter: LCD fetch (fixed 3-cycle latency, top priority),
// screen-clear engine, then CPU valid/ready port. One VRAM access per cycle.
module lcd_text_arbiter #(
    parameter int                CELLS  = 1020,
    parameter int                ADDR_W = 10,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BLANK  = 8'h20
) (
    input logic               PixelClk,
    input logic               nRST,
    lcd_text_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0]   CELLS_W = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(CELLS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LCD, OWN_CPU} owner_t;

    typedef struct packed {
        owner_t            owner;
        logic              oor;
        logic [DATA_W-1:0] forced;
    } tag_t;

    clr_state_t        state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] fill, fill_n;
    logic              done_r, done_n;

    logic              ram_ce_r, ram_ce_n;
    logic              ram_we_r, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_n;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_n;

    tag_t              tag_n, tag1, tag2;
    logic              lcd_valid_r, cpu_rvalid_r;
    logic [DATA_W-1:0] lcd_data_r, cpu_rdata_r;

    logic lcd_in_range, cpu_in_range, cpu_ready, cpu_fire;

    assign lcd_in_range = ({1'b0, bus.lcd_addr} < CELLS_W);
    assign cpu_in_range = ({1'b0, bus.cpu_addr} < CELLS_W);
    // Gating with nRST keeps ready low while reset is asserted.
    assign cpu_ready    = nRST & ~bus.lcd_req & (state == S_IDLE) & ~bus.clr_start;
    assign cpu_fire     = bus.cpu_valid & cpu_ready;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        fill_n      = fill;
        done_n      = 1'b0;
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_addr_n  = ram_addr_r;
        ram_wdata_n = ram_wdata_r;
        tag_n       = '0;

        if (bus.lcd_req) begin
            tag_n.owner = OWN_LCD;
            if (lcd_in_range) begin
                ram_ce_n   = 1'b1;
                ram_addr_n = bus.lcd_addr;
            end else begin
                tag_n.oor    = 1'b1;
                tag_n.forced = BLANK;
            end
        end else if (state == S_CLEAR) begin
            ram_ce_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_addr_n  = cnt;
            ram_wdata_n = fill;
            if (cnt == LAST) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (cpu_fire) begin
            ram_addr_n = bus.cpu_addr;
            if (bus.cpu_we) begin
                // Out-of-range writes are accepted but never reach the RAM.
                ram_we_n    = 1'b1;
                ram_ce_n    = cpu_in_range;
                ram_wdata_n = bus.cpu_wdata;
            end else begin
                tag_n.owner = OWN_CPU;
                ram_ce_n    = cpu_in_range;
                tag_n.oor   = ~cpu_in_range;
            end
        end

        if ((state == S_IDLE) && bus.clr_start) begin
            state_n = S_CLEAR;
            cnt_n   = '0;
            fill_n  = bus.clr_char;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state        <= S_IDLE;
            cnt          <= '0;
            fill         <= '0;
            done_r       <= 1'b0;
            ram_ce_r     <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= '0;
            ram_wdata_r  <= '0;
            tag1         <= '0;
            tag2         <= '0;
            lcd_valid_r  <= 1'b0;
            lcd_data_r   <= '0;
            cpu_rvalid_r <= 1'b0;
            cpu_rdata_r  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            fill         <= fill_n;
            done_r       <= done_n;
            ram_ce_r     <= ram_ce_n;
            ram_we_r     <= ram_we_n;
            ram_addr_r   <= ram_addr_n;
            ram_wdata_r  <= ram_wdata_n;
            // tag2 lines up with ram_rdata for the access that tag1 issued.
            tag1         <= tag_n;
            tag2         <= tag1;
            lcd_valid_r  <= (tag2.owner == OWN_LCD);
            cpu_rvalid_r <= (tag2.owner == OWN_CPU);
            if (tag2.owner == OWN_LCD) begin
                lcd_data_r <= tag2.oor ? tag2.forced : bus.ram_rdata;
            end
            if (tag2.owner == OWN_CPU) begin
                cpu_rdata_r <= tag2.oor ? tag2.forced : bus.ram_rdata;
            end
        end
    end

    assign bus.lcd_data   = lcd_data_r;
    assign bus.lcd_valid  = lcd_valid_r;
    assign bus.cpu_ready  = cpu_ready;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.cpu_rvalid = cpu_rvalid_r;
    assign bus.clr_busy   = (state == S_CLEAR);
    assign bus.clr_done   = done_r;
    assign bus.clr_state  = state;
    assign bus.ram_ce     = ram_ce_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_wdata  = ram_wdata_r;
endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Bench for lcd_text_arbiter: behavioural VRAM, shadow memory, expected-response
// queues for the LCD and CPU read ports, and directed clear scenarios.
module tb_lcd_text_arbiter;
  localparam int CELLS = 1020;

  logic clk;
  logic nrst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   acc;

  logic [7:0] vram [0:1023];
  logic [7:0] shadow [0:1023];
  logic       preloaded = 1'b0;

  logic [7:0] lcd_exp_q[$];
  int         lcd_cyc_q[$];
  logic [7:0] cpu_exp_q[$];
  int         cpu_cyc_q[$];
  logic [7:0] mon_e;
  int         mon_c;

  lcd_text_arbiter_if bus();

  lcd_text_arbiter dut (
    .PixelClk(clk),
    .nRST(nrst),
    .bus(bus)
  );

  // clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] init_val(input int i);
    return (i == 5) ? 8'h41 : 8'(i * 7 + 3);
  endfunction

  // behavioural single-port BSRAM, read data one cycle after the access
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) vram[i] <= init_val(i);
      preloaded <= 1'b1;
    end else if (bus.ram_ce) begin
      if (bus.ram_we) vram[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= vram[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.lcd_valid, bus.lcd_data, bus.cpu_rvalid, bus.cpu_rdata, bus.clr_busy,
                bus.clr_done, bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                bus.cpu_ready, bus.clr_state});
  endfunction

  function automatic logic [7:0] lcd_exp(input logic [9:0] a);
    return (int'(a) < CELLS) ? shadow[a] : 8'h20;
  endfunction

  // scoreboard: pop on every response pulse, check data and arrival cycle
  always @(negedge clk) begin
    if (bus.lcd_valid) begin
      if (lcd_exp_q.size() == 0) chk("lcd_unexpected", 1, 0);
      else begin
        mon_e = lcd_exp_q.pop_front();
        mon_c = lcd_cyc_q.pop_front();
        chk("lcd_data", bus.lcd_data, mon_e);
        chk("lcd_latency", cyc, mon_c);
      end
    end
    if (bus.cpu_rvalid) begin
      if (cpu_exp_q.size() == 0) chk("cpu_unexpected", 1, 0);
      else begin
        mon_e = cpu_exp_q.pop_front();
        mon_c = cpu_cyc_q.pop_front();
        chk("cpu_rdata", bus.cpu_rdata, mon_e);
        chk("cpu_latency", cyc, mon_c);
      end
    end
    if (bus.clr_done) done_cnt++;
  end

  // driver tasks: all start and end one time unit after a rising edge
  task automatic lcd_fetch(input logic [9:0] a, input logic [7:0] e);
    bus.lcd_req  = 1'b1;
    bus.lcd_addr = a;
    lcd_exp_q.push_back(e);
    lcd_cyc_q.push_back(cyc + 3);
    @(posedge clk); #1;
    bus.lcd_req = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [9:0] a, input logic [7:0] d,
                            output int acc_cyc);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    acc_cyc = -1;
    for (int i = 0; i < 64 && acc_cyc < 0; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        acc_cyc = cyc;
        if (we) begin
          if (int'(a) < CELLS) shadow[a] = d;
        end else begin
          cpu_exp_q.push_back((int'(a) < CELLS) ? shadow[a] : 8'h00);
          cpu_cyc_q.push_back(cyc + 3);
        end
      end
      @(posedge clk); #1;
    end
    bus.cpu_valid = 1'b0;
    if (acc_cyc < 0) chk("cpu_accept_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_plain(input logic [7:0] fill);
    int t0, dc, viol;
    bus.clr_start = 1'b1;
    bus.clr_char  = fill;
    t0 = cyc;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    bus.clr_char  = 8'h00;
    @(negedge clk);
    chk("clr_busy_t1", bus.clr_busy, 1);
    @(negedge clk);
    chk("clr_first_wr", {bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata},
        {1'b1, 1'b1, 10'd0, fill});
    dc = -1;
    viol = 0;
    for (int i = 0; i < 1200 && dc < 0; i++) begin
      @(negedge clk);
      if (bus.clr_done) begin
        dc = cyc;
        chk("clr_busy_fall", bus.clr_busy, 0);
      end else if (bus.cpu_ready) viol++;
    end
    chk("clr_done_cycle", dc, t0 + 1 + CELLS);
    chk("clr_ready_low", viol, 0);
    @(posedge clk); #1;
    for (int i = 0; i < CELLS; i++) shadow[i] = fill;
  endtask

  task automatic clear_traffic(input logic [7:0] fill);
    int t0, written, nl, dc;
    logic sent2;
    logic [9:0] a;
    bus.clr_start = 1'b1;
    bus.clr_char  = fill;
    t0 = cyc;
    written = 0;
    nl = 0;
    sent2 = 1'b0;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    for (int g = 0; g < 3000 && written < CELLS; g++) begin
      if (cyc % 8 == 0) begin
        case (nl % 3)
          0: a = (written > 0) ? 10'(written - 1) : 10'd0;
          1: a = 10'(written);
          default: a = 10'($urandom_range(0, CELLS - 1));
        endcase
        lcd_fetch(a, (int'(a) < written) ? fill : shadow[a]);
        nl++;
      end else begin
        written++;
        if (!sent2 && written >= 300) begin
          bus.clr_start = 1'b1;
          bus.clr_char  = 8'h99;
          sent2 = 1'b1;
        end
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
      end
    end
    dc = -1;
    for (int i = 0; i < 20 && dc < 0; i++) begin
      @(negedge clk);
      if (bus.clr_done) dc = cyc;
    end
    chk("clr_traffic_done", dc, t0 + 1 + CELLS + nl);
    @(posedge clk); #1;
    for (int i = 0; i < CELLS; i++) shadow[i] = fill;
  endtask

  task automatic clear_reset(input logic [7:0] fill);
    int nd;
    logic found;
    bus.clr_start = 1'b1;
    bus.clr_char  = fill;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clk);
      if (bus.ram_ce && bus.ram_we && bus.ram_addr == 10'd500) found = 1'b1;
    end
    chk("rst_mid_found", found, 1);
    nd = done_cnt;
    nrst = 1'b0;
    #1;
    chk("rst_mid_busy", bus.clr_busy, 0);
    chk("rst_mid_outs", outs(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, nd);
    for (int i = 0; i < 500; i++) shadow[i] = fill;
  endtask

  logic [9:0] wa [8];
  logic [7:0] wd;
  int         c0;
  int         rd_list [8] = '{0, 250, 499, 500, 501, 777, 1018, 1019};

  initial begin
    nrst = 1'b0;
    bus.lcd_req = 1'b0;   bus.lcd_addr = '0;
    bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 1'b0; bus.clr_char = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

    // reset state and asynchronous reset mid-cycle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    cpu_access(1'b1, 10'd7, shadow[7], acc);
    chk("cpu_wr_t1", {bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_wdata},
        {1'b1, 1'b1, 10'd7, shadow[7]});
    #1 nrst = 1'b0;
    #1 chk("async_reset_outs", outs(), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    lcd_fetch(10'd5, 8'h41);
    idle(4);

    // out-of-range accesses
    lcd_fetch(10'd1020, 8'h20);
    @(negedge clk);
    chk("lcd_oor_ce", bus.ram_ce, 0);
    @(posedge clk); #1;
    cpu_access(1'b0, 10'd1023, 8'h00, acc);
    cpu_access(1'b1, 10'd1020, 8'h77, acc);
    @(negedge clk);
    chk("cpu_wr_oor_ce", bus.ram_ce, 0);
    chk("cpu_wr_oor_accepted", acc, cyc - 1);
    @(posedge clk); #1;
    idle(4);

    // random writes, back-to-back readback through both ports
    for (int i = 0; i < 8; i++) begin
      wa[i] = 10'($urandom_range(0, CELLS - 1));
      wd = 8'($urandom_range(0, 255));
      cpu_access(1'b1, wa[i], wd, acc);
    end
    for (int i = 0; i < 8; i++) cpu_access(1'b0, wa[i], 8'h00, acc);
    for (int i = 0; i < 8; i++) lcd_fetch(wa[7 - i], lcd_exp(wa[7 - i]));
    cpu_access(1'b1, wa[0], 8'hC3, acc);
    cpu_access(1'b0, wa[0], 8'h00, acc);
    idle(4);

    // LCD/CPU contention in the same cycle
    c0 = cyc;
    fork
      lcd_fetch(10'd10, lcd_exp(10'd10));
      cpu_access(1'b1, 10'd3, 8'h55, acc);
    join
    chk("contention_accept", acc, c0 + 1);
    cpu_access(1'b0, 10'd3, 8'h00, acc);
    idle(4);

    // clear without interference, full readback
    clear_plain(8'h2E);
    for (int i = 0; i < CELLS; i++) cpu_access(1'b0, 10'(i), 8'h00, acc);
    idle(4);

    // clear with LCD traffic and an ignored second start
    clear_traffic(8'h3A);
    for (int i = 0; i < CELLS; i += 17) cpu_access(1'b0, 10'(i), 8'h00, acc);
    cpu_access(1'b0, 10'd1019, 8'h00, acc);
    idle(4);

    // reset in the middle of a clear
    clear_reset(8'h7F);
    for (int i = 0; i < 8; i++) cpu_access(1'b0, 10'(rd_list[i]), 8'h00, acc);
    idle(6);

    chk("lcd_queue_drained", lcd_exp_q.size(), 0);
    chk("cpu_queue_drained", cpu_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_text_arbiter.md
# lcd_text_arbiter

Shares the single-port text VRAM (BSRAM, one character code per 8x16 cell, 60x17 cells) between three requesters: the LCD pixel pipeline's character fetch, the CPU bus, and a built-in screen-clear engine. Runs entirely in the `PixelClk` domain, between the `lcd` controller's character-fetch port and the VRAM primitive. The LCD fetch has fixed latency and absolute priority. The CPU gets a valid/ready port. Clear fills every cell with one character code.

## Interface
- `CELLS`, default 1020: number of valid cells (60x17); legal addresses are 0..CELLS-1.
- `ADDR_W`, default 10: VRAM address width.
- `DATA_W`, default 8: character code width.
- `BLANK`, default 8'h20: code returned to the LCD for out-of-range addresses.

Ports:
- `PixelClk` input, 1: sole clock, 9 MHz.
- `nRST` input, 1: reset, asynchronous, active-low.
- `lcd_req` input, 1: LCD fetch strobe for one cycle.
- `lcd_addr` input, ADDR_W: fetch address, valid with `lcd_req`.
- `lcd_data` output, DATA_W: fetched code.
- `lcd_valid` output, 1: one-cycle pulse qualifying `lcd_data`.
- `cpu_valid` input, 1: CPU request; held until accepted.
- `cpu_we` input, 1: 1 = write, 0 = read.
- `cpu_addr` input, ADDR_W: CPU address.
- `cpu_wdata` input, DATA_W: CPU write data.
- `cpu_ready` output, 1: a request is accepted in a cycle where `cpu_valid & cpu_ready`.
- `cpu_rdata` output, DATA_W: read data.
- `cpu_rvalid` output, 1: one-cycle pulse qualifying `cpu_rdata`.
- `clr_start` input, 1: clear command pulse.
- `clr_char` input, DATA_W: fill code, sampled with `clr_start`.
- `clr_busy` output, 1: clear in progress.
- `clr_done` output, 1: one-cycle pulse when the clear completes.
- `ram_ce`, `ram_we` outputs, 1 each: VRAM enable and write enable.
- `ram_addr` output, ADDR_W: VRAM address.
- `ram_wdata` output, DATA_W: VRAM write data.
- `ram_rdata` input, DATA_W: VRAM read data; valid one cycle after the read is issued.

## Operation
- **Priority each cycle:** LCD > clear > CPU. At most one VRAM access is issued per cycle.
- **LCD path:**
  - Every `lcd_req` is served the next cycle. It is never stalled or dropped.
  - If `lcd_addr >= CELLS`, no RAM access is issued and `lcd_data = BLANK`.
- **CPU ready:** `cpu_ready = !lcd_req & !clr_busy & !clr_start`. It is combinational and 0 during reset.
- **CPU write:** issues `ram_we=1`. If `cpu_addr >= CELLS`, the write is accepted but dropped (`ram_ce=0`).
- **CPU read:** returns `cpu_rdata` with a `cpu_rvalid` pulse. If out of range, returns 8'h00 with no RAM access.
- **CPU writes** produce no response pulse.
- **Clear FSM states:** IDLE, CLEAR.
  - IDLE -> CLEAR on `clr_start`. The FSM latches `clr_char` and sets the 10-bit cell counter to 0.
  - In CLEAR, the engine writes the counter's cell and increments the counter in each cycle without `lcd_req`. In a cycle with `lcd_req`, the counter holds.
  - After writing cell CELLS-1: CLEAR -> IDLE, `clr_busy` falls, and `clr_done` pulses once in that same cycle.
  - `clr_start` while in CLEAR is ignored.
- **Read pipeline:** a two-stage tag pipeline (owner LCD/CPU/none, out-of-range flag, forced value) follows each read through to its response. Tags never cross: responses appear in issue order.

## Timing
- **Reset:** all outputs 0 and the FSM in IDLE. This covers `lcd_valid`, `lcd_data`, `cpu_rvalid`, `cpu_rdata`, `clr_busy`, `clr_done`, `ram_*` and `cpu_ready`.
- **Reset mid-clear:** aborts the clear with no `clr_done`. Cells already written stay written.
- **Read latency:** a request presented/accepted in cycle t produces:
  - `ram_*` (registered) driven in t+1,
  - `ram_rdata` in t+2,
  - the registered `lcd_data`/`lcd_valid` or `cpu_rdata`/`cpu_rvalid` in t+3.
  - Latency is 3 cycles for both requesters, including out-of-range reads.
- **Write timing:** a CPU write accepted in t appears on `ram_*` in t+1.
- **Clear timing:**
  - With `clr_start` in t, `clr_busy`=1 from t+1, and the first clear write appears on `ram_*` in t+2.
  - With no LCD interference, `clr_done` appears in t+1+CELLS = t+1021. Each stalled cycle adds one cycle.
- **Throughput:** back-to-back `lcd_req` every cycle is supported. Back-to-back CPU accesses run one per cycle when `cpu_ready` stays 1.

## Test plan
- **Reset:** preload VRAM[5]=8'h41, assert `nRST` low asynchronously mid-cycle. All outputs go 0 immediately. Release; `lcd_req` at addr 5 in t -> `lcd_valid`=1 with `lcd_data`=8'h41 in t+3.
- **Out of range:** `lcd_req` addr 1020 -> `lcd_data`=8'h20 at t+3 with `ram_ce`=0. CPU read addr 1023 -> `cpu_rdata`=8'h00 at t+3. CPU write addr 1020 -> accepted, `ram_ce`=0.
- **LCD/CPU contention:** `lcd_req` and `cpu_valid` (write addr 3 = 8'h55) in the same cycle -> `cpu_ready`=0, LCD served. The write is accepted the next cycle and a readback of addr 3 returns 8'h55.
- **Clear without interference:** `clr_start` with `clr_char`=8'h2E in t -> `clr_busy` in t+1, `clr_done` in t+1021. All 1020 cells read 8'h2E. `cpu_ready`=0 throughout.
- **Clear with LCD traffic:** `lcd_req` every 8th cycle during a clear -> every LCD read returns the correct current value at t+3. `clr_done` is delayed by exactly the number of `lcd_req` cycles. A second `clr_start` mid-clear is ignored.
- **Reset mid-clear:** `nRST` low at cell 500 -> `clr_busy`=0 and no `clr_done`. Cells 0..499 hold the fill code; cells 500 and up are unchanged.
